// File: rtl/frame_composer.sv
// frame_composer: flappy-bird game state (bird, pipe, score) plus frame renderer.
// Renders one row per cycle into a shadow buffer, then presents the finished
// frame to the matrix driver over the e_disp_o / d_disp_i handshake.
// Optional build macro FRAME_COMPOSER_FLASH_EN: blink the frozen frame after game over.
module frame_composer #(
  parameter int GS         = 8,
  parameter int SCROLL_DIV = 4,
  parameter int BIRD_COL   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flap_i,
  input  logic             d_disp_i,
  output logic [GS*GS-1:0] matrix_o,
  output logic             e_disp_o,
  output logic [3:0]       score_o,
  output logic             game_over_o
);

  localparam int RW = $clog2(GS);
  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [RW-1:0] ROW_MAX = RW'(GS - 1);
  localparam logic [RW-1:0] ROW_MID = RW'(GS / 2);
  localparam logic [RW-1:0] GAP_MAX = RW'(GS - 3);
  localparam logic [RW-1:0] TWO     = RW'(2);
  localparam logic [RW-1:0] ONE     = RW'(1);
  localparam logic [RW-1:0] BCOL    = RW'(BIRD_COL);
  localparam logic [SW-1:0] SC_MAX  = SW'(SCROLL_DIV - 1);

  typedef enum logic [1:0] {IDLE, RENDER, SHOW, UPDATE} state_t;

  state_t            state, state_nxt;
  logic [RW-1:0]     row_cnt;
  logic [GS*GS-1:0]  shadow, shadow_nxt;
  logic [GS-1:0]     row_bits;
  logic              pipe_hit, blank;

  logic [RW-1:0]     bird_row, pipe_col, gap_top;
  logic [SW-1:0]     scroll_cnt;
  logic [7:0]        lfsr;
  logic              flap_q, flap_pending, flap_edge;
  logic [RW-1:0]     gap_new;

  logic [RW-1:0]     n_bird, n_pipe, n_gap;
  logic [SW-1:0]     n_scroll;
  logic [3:0]        n_score;
  logic              n_over;

  assign flap_edge = flap_i & ~flap_q;
  assign gap_new   = (lfsr[RW-1:0] > GAP_MAX) ? GAP_MAX : lfsr[RW-1:0];

`ifdef FRAME_COMPOSER_FLASH_EN
  logic flash_tog;
  assign blank = game_over_o & flash_tog;

  // blink phase: restarts at 0 on the step that ends the game, then flips every step
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  flash_tog <= 1'b0;
    else if (state == UPDATE)   flash_tog <= game_over_o ? ~flash_tog : 1'b0;
  end
`else
  assign blank = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: one idle cycle, GS render cycles, wait for the driver, one step
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = RENDER;
      RENDER:  if (row_cnt == ROW_MAX) state_nxt = SHOW;
      SHOW:    if (d_disp_i) state_nxt = UPDATE;
      UPDATE:  state_nxt = RENDER;
      default: state_nxt = IDLE;
    endcase
  end

  // one pixel per column for the row currently being rendered
  assign pipe_hit = (row_cnt < gap_top) || (row_cnt > gap_top + TWO);
  for (genvar c = 0; c < GS; c++) begin : g_col
    localparam logic [RW-1:0] CI = RW'(c);
    assign row_bits[c] = ~blank & (((CI == BCOL) && (row_cnt == bird_row)) ||
                                   ((CI == pipe_col) && pipe_hit));
  end

  // shadow buffer with the current row merged in
  always_comb begin
    shadow_nxt = shadow;
    shadow_nxt[row_cnt*GS +: GS] = row_bits;
  end

  // render into the shadow; publish the whole frame on the last row so matrix_o
  // only ever changes on the edge where e_disp_o rises
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_cnt  <= '0;
      shadow   <= '0;
      matrix_o <= '0;
      e_disp_o <= 1'b0;
    end else begin
      if (state == RENDER) begin
        shadow  <= shadow_nxt;
        row_cnt <= row_cnt + ONE;
        if (row_cnt == ROW_MAX) begin
          matrix_o <= shadow_nxt;
          e_disp_o <= 1'b1;
        end
      end
      if (state == SHOW && d_disp_i) e_disp_o <= 1'b0;
    end
  end

  // free-running LFSR and flap latch; an edge during UPDATE survives into the next step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr         <= 8'hA5;
      flap_q       <= 1'b0;
      flap_pending <= 1'b0;
    end else begin
      lfsr         <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      flap_q       <= flap_i;
      flap_pending <= (state == UPDATE) ? flap_edge : (flap_pending | flap_edge);
    end
  end

  // game step: restart/freeze when over, else bird, scroll, then collision on the moved state
  always_comb begin
    n_bird   = bird_row;
    n_pipe   = pipe_col;
    n_gap    = gap_top;
    n_scroll = scroll_cnt;
    n_score  = score_o;
    n_over   = game_over_o;
    if (game_over_o) begin
      if (flap_pending) begin
        n_score = 4'd0;
        n_bird  = ROW_MID;
        n_pipe  = ROW_MAX;
        n_over  = 1'b0;
      end
    end else begin
      if (flap_pending)              n_bird = (bird_row < TWO) ? '0 : bird_row - TWO;
      else if (bird_row == ROW_MAX)  n_over = 1'b1;
      else                           n_bird = bird_row + ONE;

      if (scroll_cnt == SC_MAX) begin
        n_scroll = '0;
        if (pipe_col == '0) begin
          n_pipe = ROW_MAX;
          n_gap  = gap_new;
        end else begin
          n_pipe = pipe_col - ONE;
          if (pipe_col == BCOL) n_score = (score_o == 4'd9) ? 4'd0 : score_o + 4'd1;
        end
      end else begin
        n_scroll = scroll_cnt + SW'(1);
      end

      if (n_pipe == BCOL && (n_bird < n_gap || n_bird > n_gap + TWO)) n_over = 1'b1;
    end
  end

  // commit the game step once per displayed frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bird_row    <= ROW_MID;
      pipe_col    <= ROW_MAX;
      gap_top     <= TWO;
      scroll_cnt  <= '0;
      score_o     <= 4'd0;
      game_over_o <= 1'b0;
    end else if (state == UPDATE) begin
      bird_row    <= n_bird;
      pipe_col    <= n_pipe;
      gap_top     <= n_gap;
      scroll_cnt  <= n_scroll;
      score_o     <= n_score;
      game_over_o <= n_over;
    end
  end

endmodule

// File: tb/tb_frame_composer.sv
// Bench for frame_composer: frame-level game model checked every cycle,
// plus directed literal frames for reset, latency, flap, ground, restart, reset mid-render.
module tb_frame_composer;
  localparam int GS = 8;
  localparam int SD = 4;
  localparam int BC = 1;

  logic clk = 1'b0, reset = 1'b1, flap_i = 1'b0, d_disp_i = 1'b0;
  logic [GS*GS-1:0] matrix_o;
  logic             e_disp_o;
  logic [3:0]       score_o;
  logic             game_over_o;

  int total = 0;
  int bad   = 0;

  frame_composer #(.GS(GS), .SCROLL_DIV(SD), .BIRD_COL(BC)) dut (
    .clk(clk), .reset(reset), .flap_i(flap_i), .d_disp_i(d_disp_i),
    .matrix_o(matrix_o), .e_disp_o(e_disp_o), .score_o(score_o), .game_over_o(game_over_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_bird, m_pipe, m_gap, m_score, m_scroll, m_wait;
  bit         m_over, m_pend, m_fq, m_e, m_upd, m_tog, m_edg;
  logic [7:0] m_lfsr;
  logic [63:0] m_mat;

  task automatic m_init();
    m_bird = GS/2; m_pipe = GS-1; m_gap = 2; m_score = 0; m_scroll = 0;
    m_over = 0; m_pend = 0; m_fq = 0; m_e = 0; m_upd = 0; m_tog = 0;
    m_lfsr = 8'hA5; m_mat = '0; m_wait = GS+1;
  endtask

  function automatic logic [63:0] frame();
    logic [63:0] f;
    f = '0;
    for (int r = 0; r < GS; r++)
      for (int c = 0; c < GS; c++)
        if ((c == BC && r == m_bird) || (c == m_pipe && (r < m_gap || r > m_gap + 2)))
          f[r*GS + c] = 1'b1;
`ifdef FRAME_COMPOSER_FLASH_EN
    if (m_over && m_tog) f = '0;
`endif
    return f;
  endfunction

  task automatic m_step();
    int lo;
    m_tog = m_over ? !m_tog : 1'b0;
    if (m_over) begin
      if (m_pend) begin
        m_score = 0; m_bird = GS/2; m_pipe = GS-1; m_over = 0;
      end
    end else begin
      if (m_pend)                m_bird = (m_bird - 2 < 0) ? 0 : m_bird - 2;
      else if (m_bird == GS-1)   m_over = 1;
      else                       m_bird = m_bird + 1;
      m_scroll = m_scroll + 1;
      if (m_scroll == SD) begin
        m_scroll = 0;
        if (m_pipe == 0) begin
          m_pipe = GS-1;
          lo = int'(m_lfsr) % GS;
          m_gap = (lo > GS-3) ? GS-3 : lo;
        end else begin
          if (m_pipe == BC) m_score = (m_score + 1) % 10;
          m_pipe = m_pipe - 1;
        end
      end
      if (m_pipe == BC && (m_bird < m_gap || m_bird > m_gap + 2)) m_over = 1;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) m_init();
    else begin
      m_edg = flap_i && !m_fq;
      m_fq  = flap_i;
      if (m_upd) begin
        m_step();
        m_pend = m_edg;
        m_upd  = 0;
      end else if (m_edg) m_pend = 1;
      if (!m_e) begin
        m_wait--;
        if (m_wait == 0) begin
          m_e   = 1;
          m_mat = frame();
        end
      end else if (d_disp_i) begin
        m_e = 0; m_wait = GS+1; m_upd = 1;
      end
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("e_disp",    64'(e_disp_o),    64'(m_e));
    chk("matrix",    matrix_o,         m_mat);
    chk("score",     64'(score_o),     64'(m_score));
    chk("game_over", 64'(game_over_o), 64'(m_over));
  end

  // ---------------- stimulus ----------------
  task automatic handshake(output int low);
    d_disp_i = 1'b1;
    @(negedge clk);
    d_disp_i = 1'b0;
    low = 0;
    while (!e_disp_o && low < 100) begin
      low++;
      @(negedge clk);
    end
    chk("frame_arrives", 64'(e_disp_o), 64'd1);
  endtask

  task automatic wait_first(input string name);
    int cyc;
    cyc = 0;
    while (!e_disp_o && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk(name, 64'(cyc), 64'(GS+1));
  endtask

  initial begin
    int low, steps;
    bit saw9, wrapped;
    repeat (2) @(negedge clk);
    chk("reset_e", 64'(e_disp_o), 64'd0);
    chk("reset_mat", matrix_o, 64'd0);
    reset = 1'b0;

    wait_first("first_frame_cycle");
    chk("frame0", matrix_o, 64'h80808002_00008080);

    handshake(low);
    chk("latency", 64'(low), 64'(GS+1));
    chk("frame1", matrix_o, 64'h80808200_00008080);

    // flap from row 5, then keep the button held: only one flap
    flap_i = 1'b1;
    @(negedge clk);
    handshake(low);
    chk("flap_frame", matrix_o, 64'h80808000_02008080);
    handshake(low);
    chk("held_no_flap", matrix_o, 64'h80808002_00008080);
    flap_i = 1'b0;

    // fall to the ground
    repeat (3) handshake(low);
    chk("pre_ground", 64'(game_over_o), 64'd0);
    handshake(low);
    chk("ground_over", 64'(game_over_o), 64'd1);
    chk("ground_frame", matrix_o, 64'h42404000_00004040);
    handshake(low);
`ifdef FRAME_COMPOSER_FLASH_EN
    chk("frozen_frame", matrix_o, 64'd0);
`else
    chk("frozen_frame", matrix_o, 64'h42404000_00004040);
`endif

    // restart from game over
    flap_i = 1'b1;
    @(negedge clk);
    flap_i = 1'b0;
    handshake(low);
    chk("restart_over", 64'(game_over_o), 64'd0);
    chk("restart_score", 64'(score_o), 64'd0);
    chk("restart_frame", matrix_o, 64'h80808002_00008080);

    // keep the bird in the gap until the score wraps 9 -> 0
    steps = 0; saw9 = 0; wrapped = 0;
    while (!wrapped && steps < 600) begin
      if (m_bird > m_gap + 1) begin
        flap_i = 1'b1;
        @(negedge clk);
        flap_i = 1'b0;
      end
      handshake(low);
      if (score_o == 4'd9) saw9 = 1;
      if (saw9 && score_o == 4'd0) wrapped = 1;
      steps++;
    end
    chk("score_wrap", 64'(wrapped), 64'd1);
    chk("alive", 64'(game_over_o), 64'd0);

    // asynchronous reset in the middle of RENDER
    d_disp_i = 1'b1;
    @(negedge clk);
    d_disp_i = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrender_e", 64'(e_disp_o), 64'd0);
    chk("midrender_mat", matrix_o, 64'd0);
    chk("midrender_score", 64'(score_o), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_first("rerun_first_cycle");
    chk("rerun_frame", matrix_o, 64'h80808002_00008080);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/frame_composer.md
# frame_composer

Game-state engine and frame producer for the LED-matrix display. It holds the bird, pipe and score state and renders each new frame into a GS×GS bitmap. It hands the frame to the matrix display driver over the enable/done handshake: `e_disp_o` out, `d_disp_i` back. It sits between the button inputs and the display driver in the flappy-bird top level, and also supplies the score digit to the seven-segment decoder.

## Interface
- `GS`, 8, matrix side length; power of two, 4..16
- `SCROLL_DIV`, 4, game steps per one-column pipe shift; must be ≥1
- `BIRD_COL`, 1, fixed bird column; must be 1..GS-2

- `clk` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-high; top level drives it as `!rst_n`
- `flap_i` in 1: flap button, already synchronised; rising edge counts
- `d_disp_i` in 1: display finished scanning current frame
- `matrix_o` out GS*GS: frame; bit r*GS+c = row r (0 = top), column c (0 = left)
- `e_disp_o` out 1: frame valid, display may scan
- `score_o` out 4: score digit, 0..9
- `game_over_o` out 1: collision occurred, game frozen

## Operation
- **State after reset:**
  - bird_row = GS/2, pipe_col = GS-1, scroll_cnt = 0
  - LFSR = 8'hA5, gap_top = 2
  - flap_pending = 0, score = 0, game_over = 0
- **LFSR:** 8-bit Fibonacci, x^8+x^6+x^5+x^4+1. It advances every clock.
- **Gap:** gap_top is min(lfsr[log2(GS)-1:0], GS-3). The gap spans rows gap_top..gap_top+2.
- **Flap latch:**
  - A rising edge of `flap_i` (compared with its previous-cycle sample) sets flap_pending.
  - UPDATE clears flap_pending.
  - An edge that coincides with UPDATE is latched for the next step.
- **FSM states:** IDLE → RENDER → SHOW → UPDATE → RENDER …
  - IDLE: one cycle after reset.
  - RENDER: GS cycles. Row k is written into the shadow buffer on RENDER cycle k.
    - Pixel set if (c == BIRD_COL && r == bird_row).
    - Pixel also set if (c == pipe_col && (r < gap_top || r > gap_top+2)).
  - SHOW: `matrix_o` is loaded from shadow and `e_disp_o` is set. Both are held until `d_disp_i`=1.
  - UPDATE: one cycle. The game step runs in order:
    1. If game_over: if flap_pending, reinitialise all game state (score = 0, bird_row = GS/2, pipe_col = GS-1, game_over = 0). The LFSR is not reset. Otherwise leave state unchanged.
    2. Bird:
       - flap_pending → bird_row = max(bird_row-2, 0).
       - Else bird_row == GS-1 → game_over = 1 and bird_row unchanged.
       - Else bird_row + 1.
    3. Scroll: scroll_cnt increments.
       - At SCROLL_DIV-1 it wraps to 0 and the pipe moves.
       - pipe_col == 0 → pipe_col = GS-1 and gap_top resampled from the LFSR.
       - Else pipe_col - 1.
       - A move from BIRD_COL to BIRD_COL-1 increments the score mod 10.
    4. Collision: after the move, pipe_col == BIRD_COL and bird_row outside the gap → game_over = 1.
- **Outputs:** `score_o` and `game_over_o` are registered state.
- **Handshake:** `d_disp_i` is ignored outside SHOW.

## Timing
- **Reset values:** `matrix_o`=0, `e_disp_o`=0, `score_o`=0, `game_over_o`=0. FSM = IDLE.
- **First frame:** `e_disp_o` rises on cycle GS+1 after reset release. Cycle 0 is IDLE; cycles 1..GS are RENDER.
- **Handshake latency:** `d_disp_i` sampled high in SHOW at edge N gives:
  - `e_disp_o`=0 from N+1 (UPDATE)
  - RENDER from N+2 through N+1+GS
  - `e_disp_o`=1 with the new `matrix_o` from N+2+GS
- **Game pacing:** exactly one game step per displayed frame.
- **Frame stability:** `matrix_o` changes only on the edge where `e_disp_o` rises, never while `e_disp_o`=1.
- **Reset mid-operation:** asserting `reset` forces all reset values immediately, including mid-RENDER or mid-SHOW.

## Configuration
- **`FRAME_COMPOSER_FLASH_EN` defined:** while game_over=1, alternate frames render blank. A toggle flips each UPDATE, and a blank frame has all `matrix_o` bits 0. The first frame after game over is shown non-blank.
- **Not defined:** the frozen frame is re-rendered unchanged on every step.

## Test plan
- **Reset:** release reset, hold `d_disp_i`=0. Expect `e_disp_o`=1 on cycle 9. `matrix_o` shows:
  - bit 4*8+1 set
  - column 7 set at rows 0,1,5,6,7
  - all else 0
- **Latency:** pulse `d_disp_i` for one cycle in SHOW. Expect `e_disp_o` low for exactly GS+1=9 cycles; new frame has bird at row 5, pipe still at column 7.
- **Flap:** rising edge on `flap_i` with bird_row=5, then complete a handshake. Expect bird_row=3. A held-high `flap_i` gives no second flap.
- **Ground:** no flaps, handshake repeatedly with SCROLL_DIV=4. Bird reaches row 7, and on the next step `game_over_o`=1. Further steps leave `matrix_o` unchanged; with the macro defined, frames alternate with all-zero.
- **Score:** with SCROLL_DIV=1, flap to keep the bird inside the gap. Expect `score_o` to increment by 1 when pipe_col goes 1→0, wrap 9→0, and pipe_col reload to 7.
- **Restart:**
  - In game over, a flap edge followed by a handshake gives score 0, game_over 0, bird row 4, pipe column 7.
  - Asserting `reset` mid-RENDER drops `e_disp_o` and `matrix_o` to 0 immediately.
